ext_bus_ctrl: RTL
=================

EXT_BUS_CTRL -- requirements
Module: ext_bus_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, strobe width in clk cycles; legal range 1..15.
REQ-002 Parameter TURN_CYCLES, default 1, bus-release cycles after a read; legal range 1..15.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  transaction request, sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  8  transaction address; sampled with req.
REQ-008 wdata  input  16  write data; sampled with req.
REQ-009 busy  output  1  high while the state is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rdata  output  16  last read data, held until the next read completes.
REQ-012 bus_addr  output  8  external address.
REQ-013 bus_oe_n  output  1  external output enable, active low.
REQ-014 bus_we_n  output  1  external write strobe, active low.
REQ-015 io_i  output  16  data to the bidirectional pad buffer I input.
REQ-016 io_t  output  1  pad buffer tristate control; 1 = released (high-Z), 0 = driven.
REQ-017 io_o  input  16  data from the pad buffer O output.

Function
REQ-018 The FSM SHALL use these states: IDLE, SETUP, STROBE, HOLD (write only), TURN (read only).
REQ-019 All bus outputs, busy and done SHALL be registered.
REQ-020 In IDLE, when req=1 is sampled, the block SHALL latch we, addr and wdata and enter SETUP; req is ignored in every other state.
REQ-021 SETUP SHALL last 1 cycle: bus_addr valid, strobes high; io_t=0 with io_i=wdata for a write, io_t=1 for a read.
REQ-022 STROBE SHALL last exactly WAIT_CYCLES cycles, timed by a 4-bit down-counter.
REQ-023 During a write STROBE, bus_we_n=0 and bus_oe_n=1; during a read STROBE, bus_oe_n=0 and bus_we_n=1.
REQ-024 Write HOLD SHALL last 1 cycle with bus_we_n=1 and io_t=0, keeping data driven past the strobe's rising edge.
REQ-025 A read SHALL capture io_o into rdata at the clock edge ending the last STROBE cycle.
REQ-026 Read TURN SHALL last TURN_CYCLES cycles with bus_oe_n=1 and io_t=1, so the external device releases the bus before any later drive.
REQ-027 On leaving HOLD or TURN, the block SHALL enter IDLE and assert done for exactly the first IDLE cycle.
REQ-028 A req sampled in that same done cycle SHALL be accepted, so back-to-back transactions are legal.
REQ-029 Latency from the req-sampling edge to done: write = WAIT_CYCLES+3 cycles; read = WAIT_CYCLES+TURN_CYCLES+2 cycles.
REQ-030 io_t SHALL be 1 in every state except write SETUP, STROBE and HOLD.
REQ-031 bus_oe_n and bus_we_n SHALL never both be 0 in the same cycle.
REQ-032 bus_addr and io_i SHALL hold their last value in IDLE.
REQ-033 If WAIT_CYCLES is out of range, the counter SHALL saturate at 15; a value of 0 is treated as 1.

Reset
REQ-034 Reset asserted SHALL immediately force the following, independent of clk: state=IDLE, io_t=1, bus_oe_n=1, bus_we_n=1, busy=0, done=0, rdata=0x0000, bus_addr=0x00, io_i=0x0000.
REQ-035 Reset during any state SHALL abort the transaction with no done pulse; rdata is cleared.
REQ-036 After reset deasserts, the first req SHALL be accepted on the first rising edge at which it is sampled.

Verification (WAIT_CYCLES=2, TURN_CYCLES=1; cycle 0 = req sample edge)
REQ-037 Write: we=1, addr=0x12, wdata=0xA5A5 -> io_t=0 for cycles 1-4, io_i=0xA5A5, bus_we_n=0 in cycles 2-3, done=1 in cycle 5, busy=1 in cycles 1-4.
REQ-038 Read: we=0, addr=0x34; the model drives io_o=0x3C3C while bus_oe_n=0 -> bus_oe_n=0 in cycles 2-3, io_t=1 throughout, rdata=0x3C3C from cycle 4, done=1 in cycle 5.
REQ-039 Back-to-back: read, then write requested in the read's done cycle -> write SETUP in the next cycle, with at least 1 cycle of bus_oe_n=1 and io_t=1 before io_t=0.
REQ-040 Req while busy: req pulsed in cycle 2 of a write -> ignored; exactly one done pulse; the latched addr and wdata are unchanged.
REQ-041 Reset mid-write: reset in cycle 3 -> io_t=1 and bus_we_n=1 without waiting for a clk edge, busy=0, no done pulse; a subsequent read completes normally.
REQ-042 Assertions checked every cycle: bus_oe_n and bus_we_n never both 0; io_t=0 never coincides with bus_oe_n=0.

Source files
------------

// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: single-master controller for an asynchronous external bus
// with a shared, bidirectional 16-bit data path through a pad buffer.
// A transaction runs SETUP -> STROBE (WAIT_CYCLES) -> HOLD (writes) or
// TURN (TURN_CYCLES, reads). A one-cycle done pulse follows in IDLE.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   req       transaction request, only looked at in IDLE
//   we        1 = write, 0 = read, sampled with req
//   addr      8-bit address, sampled with req
//   wdata     16-bit write data, sampled with req
//   busy      high while a transaction is in flight
//   done      one-cycle completion pulse
//   rdata     last read data, held until the next read completes
//   bus_addr  external address
//   bus_oe_n  external output enable, active low
//   bus_we_n  external write strobe, active low
//   io_i      data to the pad buffer I input
//   io_t      pad buffer tristate control (1 = released)
//   io_o      data from the pad buffer O output
module ext_bus_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic [7:0]  bus_addr,
  output logic        bus_oe_n,
  output logic        bus_we_n,
  output logic [15:0] io_i,
  output logic        io_t,
  input  logic [15:0] io_o
);

  // Out-of-range widths are clamped to what the 4-bit counter can time.
  localparam int WAIT_SAT = (WAIT_CYCLES < 1) ? 1 : (WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES;
  localparam int TURN_SAT = (TURN_CYCLES < 1) ? 1 : (TURN_CYCLES > 15) ? 15 : TURN_CYCLES;
  // The counter is loaded with width-1 and the phase ends when it reads 0.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_SAT - 1);
  localparam logic [3:0] TURN_LOAD = 4'(TURN_SAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg, we_next;
  logic        busy_next, done_next;
  logic        oe_n_next, we_n_next, io_t_next;
  logic [7:0]  bus_addr_next;
  logic [15:0] io_i_next, rdata_next;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    we_next       = we_reg;
    bus_addr_next = bus_addr;
    io_i_next     = io_i;
    rdata_next    = rdata;

    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next    = SETUP;
          we_next       = we;
          bus_addr_next = addr;
          // Reads leave io_i untouched; the pad is released anyway.
          if (we) io_i_next = wdata;
        end
      end
      SETUP: begin
        state_next = STROBE;
        cnt_next   = WAIT_LOAD;
      end
      STROBE: begin
        if (cnt_reg == 4'd0) begin
          if (we_reg) begin
            state_next = HOLD;
          end else begin
            state_next = TURN;
            cnt_next   = TURN_LOAD;
            // This edge closes the last cycle with bus_oe_n low.
            rdata_next = io_o;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      HOLD: begin
        state_next = IDLE;
      end
      TURN: begin
        if (cnt_reg == 4'd0) state_next = IDLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being
    // entered; they then line up exactly with the state register.
    busy_next = (state_next != IDLE);
    done_next = (state_next == IDLE) && ((state_reg == HOLD) || (state_reg == TURN));
    oe_n_next = 1'b1;
    we_n_next = 1'b1;
    io_t_next = 1'b1;
    case (state_next)
      SETUP: begin
        io_t_next = ~we_next;
      end
      STROBE: begin
        io_t_next = ~we_next;
        we_n_next = ~we_next;
        oe_n_next = we_next;
      end
      HOLD: begin
        // Keep driving past the rising edge of the write strobe.
        io_t_next = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 16'h0000;
      bus_addr  <= 8'h00;
      bus_oe_n  <= 1'b1;
      bus_we_n  <= 1'b1;
      io_i      <= 16'h0000;
      io_t      <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      busy      <= busy_next;
      done      <= done_next;
      rdata     <= rdata_next;
      bus_addr  <= bus_addr_next;
      bus_oe_n  <= oe_n_next;
      bus_we_n  <= we_n_next;
      io_i      <= io_i_next;
      io_t      <= io_t_next;
    end
  end

endmodule
